sha3_multicore_dispatcher: RTL and testbench

SHA3_MULTICORE_DISPATCHER -- requirements
Module: sha3_multicore_dispatcher

---
 rtl/sha3_multicore_dispatcher.sv | 168 ++++++++++++++++
 tb/tb_sha3_multicore_dispatcher.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_multicore_dispatcher.sv
// sha3_multicore_dispatcher: fans one mining job out to CORES scanner cores, collects the first win.
// Latency: start -> ready is 4 cycles minimum (LAUNCH, SETTLE, SCAN, DONE); SCAN lasts until all cores report ready.
// Backpressure: start is only honoured while ready=1 (IDLE/DONE); start while busy is dropped.
//
// Ports:
//   clk, rst (async active-low)
//   host : start, threshold[63:0], blobby[32*WORDS-1:0], base_nonce[31:0] ->
//          ready, busy, found, nonce[31:0], hash[64*25-1:0], scan_count[31:0]
//   cores: core_start[CORES], core_threshold[63:0], core_blobby[CORES*32*WORDS] <-
//          core_ready[CORES], core_found[CORES], core_nonce[CORES*32], core_hash[CORES*1600]
//   Optional: define SHA3_MULTICORE_HIT_COUNT_EN to add hit_count[7:0] (per-job found-bit count).
// Template word w occupies bits [w*32 +: 32]; core i's template starts at bit i*32*WORDS.
module sha3_multicore_dispatcher #(
  parameter int          CORES      = 4,
  parameter int          PROPER     = 1,
  parameter int          NONCE_WORD = 19,
  parameter logic [31:0] CORE_SCAN  = 32'h0100_0000
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [63:0]                                 threshold,
  input  logic [32*((PROPER != 0) ? 20 : 24)-1:0]     blobby,
  input  logic [31:0]                                 base_nonce,
  output logic                                        ready,
  output logic                                        busy,
  output logic                                        found,
  output logic [31:0]                                 nonce,
  output logic [64*25-1:0]                            hash,
  output logic [31:0]                                 scan_count,
  output logic [CORES-1:0]                            core_start,
  output logic [63:0]                                 core_threshold,
  output logic [CORES*32*((PROPER != 0) ? 20 : 24)-1:0] core_blobby,
  input  logic [CORES-1:0]                            core_ready,
  input  logic [CORES-1:0]                            core_found,
  input  logic [CORES*32-1:0]                         core_nonce,
  input  logic [CORES*64*25-1:0]                      core_hash
`ifdef SHA3_MULTICORE_HIT_COUNT_EN
  , output logic [7:0]                                hit_count
`endif
);

  localparam int          WORDS = (PROPER != 0) ? 20 : 24;
  localparam int          HW    = 64 * 25;
  localparam logic [63:0] SCAN_TOTAL = 64'(CORES) * 64'(CORE_SCAN);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_SETTLE, S_SCAN, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [63:0]         thr_q;
  logic [32*WORDS-1:0] tmpl_q;
  logic [31:0]         base_q;
  logic                won_q;
  logic                accept;
  logic                scan_end;
  logic                any_found;
  logic [31:0]         sel_nonce;
  logic [HW-1:0]       sel_hash;

  assign scan_count     = SCAN_TOTAL[31:0];
  assign core_threshold = thr_q;
  assign scan_end       = (state == S_SCAN) && (&core_ready);
  assign any_found      = |core_found;

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    core_start = '0;
    accept     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        ready  = 1'b1;
        accept = start;
        if (start) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        core_start = '1;
        state_nxt  = S_SETTLE;
      end
      S_SETTLE: state_nxt = S_SCAN;
      S_SCAN:   if (&core_ready) state_nxt = S_DONE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy = ~ready;

  // Lowest-index asserting core wins: scan downwards so lower indices overwrite
  always_comb begin
    sel_nonce = '0;
    sel_hash  = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (core_found[i]) begin
        sel_nonce = core_nonce[i*32 +: 32];
        sel_hash  = core_hash[i*HW +: HW];
      end
    end
  end

  // Per-core template: nonce word offset by i*CORE_SCAN, wrapping mod 2^32
  always_comb begin
    core_blobby = '0;
    for (int i = 0; i < CORES; i++) begin
      for (int w = 0; w < WORDS; w++) begin
        if (w == NONCE_WORD)
          core_blobby[(i*WORDS+w)*32 +: 32] = base_q + 32'(i) * CORE_SCAN;
        else
          core_blobby[(i*WORDS+w)*32 +: 32] = tmpl_q[w*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      thr_q  <= '0;
      tmpl_q <= '0;
      base_q <= '0;
      won_q  <= 1'b0;
      found  <= 1'b0;
      nonce  <= '0;
      hash   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        thr_q  <= threshold;
        tmpl_q <= blobby;
        base_q <= base_nonce;
      end
      if (state == S_LAUNCH) begin
        won_q <= 1'b0;
        found <= 1'b0;
        nonce <= '0;
        hash  <= '0;
      end
      if (state == S_SCAN && !won_q && any_found) begin
        won_q <= 1'b1;
        nonce <= sel_nonce;
        hash  <= sel_hash;
      end
      // A win in the final SCAN cycle still counts
      if (scan_end) found <= won_q | any_found;
    end
  end

`ifdef SHA3_MULTICORE_HIT_COUNT_EN
  logic [4:0] hit_inc;
  logic [8:0] hit_sum;

  always_comb begin
    hit_inc = '0;
    for (int i = 0; i < CORES; i++) hit_inc = hit_inc + 5'(core_found[i]);
    hit_sum = {1'b0, hit_count} + {4'b0, hit_inc};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count <= '0;
    end else if (state == S_LAUNCH) begin
      hit_count <= '0;
    end else if (state == S_SCAN) begin
      hit_count <= hit_sum[8] ? 8'hFF : hit_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_sha3_multicore_dispatcher.sv
module tb_sha3_multicore_dispatcher;

  localparam int          CORES = 4;
  localparam int          WORDS = 20;
  localparam int          NW    = 19;
  localparam logic [31:0] CS    = 32'h0100_0000;
  localparam int          HW    = 1600;

  logic                     clk, rst, start;
  logic [63:0]              threshold;
  logic [32*WORDS-1:0]      blobby;
  logic [31:0]              base_nonce;
  logic                     ready, busy, found;
  logic [31:0]              nonce;
  logic [HW-1:0]            hash;
  logic [31:0]              scan_count;
  logic [CORES-1:0]         core_start;
  logic [63:0]              core_threshold;
  logic [CORES*32*WORDS-1:0] core_blobby;
  logic [CORES-1:0]         core_ready, core_found;
  logic [CORES*32-1:0]      core_nonce;
  logic [CORES*HW-1:0]      core_hash;
`ifdef SHA3_MULTICORE_HIT_COUNT_EN
  logic [7:0]               hit_count;
`endif

  sha3_multicore_dispatcher #(
    .CORES(CORES), .PROPER(1), .NONCE_WORD(NW), .CORE_SCAN(CS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold), .blobby(blobby),
    .base_nonce(base_nonce), .ready(ready), .busy(busy), .found(found), .nonce(nonce),
    .hash(hash), .scan_count(scan_count), .core_start(core_start),
    .core_threshold(core_threshold), .core_blobby(core_blobby), .core_ready(core_ready),
    .core_found(core_found), .core_nonce(core_nonce), .core_hash(core_hash)
`ifdef SHA3_MULTICORE_HIT_COUNT_EN
    , .hit_count(hit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          fnd;
    logic [31:0]   nonce;
    logic [HW-1:0] hash;
    int            lat;
    int            hits;
  } res_t;

  res_t                      res_q[$];
  logic [CORES*32*WORDS-1:0] blob_q[$];
  logic [63:0]               thr_q[$];
  int n_checks = 0, n_fail = 0;
  int launches_exp = 0, launches_seen = 0;
  int d[CORES];   // first cycle (relative to start) where core i reports ready
  int f[CORES];   // cycle of core i's single found pulse, 0 = none

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Core model: cycle k after the start edge
  task automatic drive_cycle(input int k);
    for (int i = 0; i < CORES; i++) begin
      core_ready[i] = (k >= d[i]);
      core_found[i] = (f[i] != 0) && (k == f[i]);
      core_nonce[i*32 +: 32] = $urandom;
      for (int j = 0; j < HW/32; j++) core_hash[i*HW + j*32 +: 32] = $urandom;
    end
  endtask

  task automatic run_job(input logic [31:0] base, input int inject_k, input int reset_k);
    res_t                      r;
    logic [32*WORDS-1:0]       tmpl;
    logic [63:0]               thr;
    logic [CORES*32*WORDS-1:0] exp_blob;
    int K, fb, ib;
    thr = {$urandom, $urandom};
    for (int w = 0; w < WORDS; w++) tmpl[w*32 +: 32] = $urandom;
    // SCAN runs from cycle 3 until the first cycle where every core is ready
    K = 3;
    for (int i = 0; i < CORES; i++) if (d[i] > K) K = d[i];
    // Winner: earliest found pulse inside SCAN, ties to lowest index
    fb = 0; ib = -1; r.hits = 0;
    for (int i = 0; i < CORES; i++) begin
      if (f[i] >= 3 && f[i] <= K) begin
        r.hits++;
        if (ib < 0 || f[i] < fb) begin fb = f[i]; ib = i; end
      end
    end
    for (int i = 0; i < CORES; i++)
      for (int w = 0; w < WORDS; w++)
        exp_blob[(i*WORDS+w)*32 +: 32] = (w == NW) ? base + CS * 32'(i) : tmpl[w*32 +: 32];
    r.fnd = (ib >= 0); r.nonce = '0; r.hash = '0; r.lat = K;
    blob_q.push_back(exp_blob);
    thr_q.push_back(thr);
    launches_exp++;
    if (reset_k == 0) res_q.push_back(r);

    @(negedge clk);
    start = 1'b1; threshold = thr; blobby = tmpl; base_nonce = base;
    drive_cycle(0);
    for (int k = 1; k <= K + 3; k++) begin
      @(negedge clk);
      start = (k == inject_k);
      // Host inputs change after the latch; the job must not see them
      threshold = {$urandom, $urandom}; base_nonce = $urandom;
      for (int w = 0; w < WORDS; w++) blobby[w*32 +: 32] = $urandom;
      drive_cycle(k);
      if (k == fb && reset_k == 0) begin
        res_q[res_q.size()-1].nonce = core_nonce[ib*32 +: 32];
        res_q[res_q.size()-1].hash  = core_hash[ib*HW +: HW];
      end
      if (k == reset_k) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_found", 64'(found), 64'd0);
        chk("rst_nonce", 64'(nonce), 64'd0);
        chk("rst_hash", 64'(hash != '0), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        blob_q.delete(blob_q.size()-1);
        thr_q.delete(thr_q.size()-1);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          core_found = '1;
          chk("post_rst_ready", 64'(ready), 64'd1);
          chk("post_rst_no_start", 64'(core_start), 64'd0);
        end
        break;
      end
    end
    start = 1'b0;
    core_found = '0;
    core_ready = '1;
  endtask

  task automatic rand_sched(output int inject_k);
    int K;
    K = 3;
    for (int i = 0; i < CORES; i++) begin
      d[i] = $urandom_range(1, 14);
      if (d[i] > K) K = d[i];
    end
    for (int i = 0; i < CORES; i++)
      f[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, K + 2);
    inject_k = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(3, K);
  endtask

  // Monitor / scoreboard
  logic prev_ready = 1'b1, prev_cs = 1'b0;
  int   cyc = 0, start_cyc = 0;
  always @(posedge clk) begin
    res_t r;
    #1;
    if (rst) begin
      if (core_start != '0) begin
        launches_seen++;
        chk("core_start_all", 64'(core_start), 64'hF);
        chk("core_start_1cyc", 64'(prev_cs), 64'd0);
        start_cyc = cyc;
        if (blob_q.size() == 0) begin
          chk("unexpected_launch", 64'd1, 64'd0);
        end else begin
          n_checks++;
          if (core_blobby !== blob_q[0]) begin
            n_fail++;
            $display("FAIL launch_blobby: got %h expected %h (core3 nonce word)",
                     core_blobby[(3*WORDS+NW)*32 +: 32], blob_q[0][(3*WORDS+NW)*32 +: 32]);
          end
          chk("launch_threshold", core_threshold, thr_q[0]);
        end
      end
      if (ready && !prev_ready) begin
        if (res_q.size() == 0 || blob_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          r = res_q.pop_front();
          chk("done_found", 64'(found), 64'(r.fnd));
          chk("done_latency", 64'(cyc - start_cyc), 64'(r.lat));
          if (r.fnd) begin
            chk("done_nonce", 64'(nonce), 64'(r.nonce));
            chk("done_hash_lo", hash[63:0], r.hash[63:0]);
            chk("done_hash_full", 64'(hash === r.hash), 64'd1);
          end
          n_checks++;
          if (core_blobby !== blob_q[0]) begin
            n_fail++;
            $display("FAIL held_blobby: got %h expected %h (core1 nonce word)",
                     core_blobby[(WORDS+NW)*32 +: 32], blob_q[0][(WORDS+NW)*32 +: 32]);
          end
          chk("held_threshold", core_threshold, thr_q[0]);
`ifdef SHA3_MULTICORE_HIT_COUNT_EN
          chk("done_hit_count", 64'(hit_count), 64'(r.hits));
`endif
          void'(blob_q.pop_front());
          void'(thr_q.pop_front());
        end
      end
    end
    prev_ready = ready;
    prev_cs    = core_start[0];
    cyc++;
  end

  initial begin
    int inj;
    rst = 1'b0; start = 1'b0; threshold = '0; blobby = '0; base_nonce = '0;
    core_ready = '1; core_found = '0; core_nonce = '0; core_hash = '0;
    #2;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_found", 64'(found), 64'd0);
    chk("reset_nonce", 64'(nonce), 64'd0);
    chk("reset_hash", 64'(hash != '0), 64'd0);
    chk("reset_core_start", 64'(core_start), 64'd0);
    chk("reset_scan_count", 64'(scan_count), 64'h0400_0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(ready), 64'd1);

    // Minimum latency, base 0x1000
    d = '{2, 2, 2, 2}; f = '{0, 0, 0, 0};
    run_job(32'h0000_1000, 0, 0);
    chk("core3_nonce_word", 64'(core_blobby[(3*WORDS+NW)*32 +: 32]), 64'h0300_1000);

    // Nonce wrap; cores 1 and 2 win together, core 1 takes it
    d = '{8, 8, 8, 8}; f = '{0, 5, 5, 0};
    run_job(32'hFF00_0000, 0, 0);
    chk("core1_wrap_word", 64'(core_blobby[(1*WORDS+NW)*32 +: 32]), 64'h0000_0000);

    // Earlier find on a higher core beats a later lower core
    d = '{12, 12, 12, 12}; f = '{10, 0, 0, 5};
    run_job($urandom, 0, 0);

    // No finds, long scan, start issued mid-SCAN
    d = '{20, 35, 50, 10}; f = '{0, 0, 0, 0};
    run_job($urandom, 20, 0);
    chk("long_found", 64'(found), 64'd0);

    for (int j = 0; j < 25; j++) begin
      rand_sched(inj);
      run_job($urandom, inj, 0);
    end

    // Reset in SCAN after a win was already latched
    d = '{20, 20, 20, 20}; f = '{4, 0, 0, 0};
    run_job($urandom, 0, 6);

    rand_sched(inj);
    run_job($urandom, inj, 0);

    repeat (3) @(negedge clk);
    chk("results_drained", 64'(res_q.size()), 64'd0);
    chk("launch_count", 64'(launches_seen), 64'(launches_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
